fifo_nibble_packer: RTL and testbench

- Read-side consumer of the 4-bit asynchronous FIFO, in the read clock domain.
- Drains nibbles through the FIFO's rd_en/empty/data_out interface.
- Packs NIBBLES consecutive nibbles into one word and presents it downstream on a valid/ready handshake.
- Accounts for the FIFO's registered read: data_out is valid on the cycle after an accepted read (rd_en=1 and empty=0 at the edge).

---
 rtl/fifo_nibble_packer.sv | 112 +++++++++++
 tb/tb_fifo_nibble_packer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_nibble_packer.sv
// Read-domain consumer of a 4-bit FIFO: packs NIBBLES nibbles (first read in the LSBs) into one
// word on a valid/ready output. Optional out_parity port when PACKER_PARITY_EN is defined.
module fifo_nibble_packer #(
  parameter  int NIBBLES = 2,
  localparam int W       = 4 * NIBBLES,
  localparam int CW      = $clog2(NIBBLES + 1)
) (
  input  logic         rd_clk,
  input  logic         rd_rst,
  input  logic         fifo_empty,
  input  logic [3:0]   fifo_data,
  output logic         fifo_rd_en,
  output logic [W-1:0] out_word,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
`ifdef PACKER_PARITY_EN
  ,
  output logic         out_parity
`endif
);

  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CW-1:0] NIB_CNT  = CW'(NIBBLES);
  localparam logic [CW:0]   NIB_WIDE = (CW + 1)'(NIBBLES);

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           pend, pend_d;
  logic [W-1:0]   asm_word, asm_d;
  logic [W-1:0]   word_d;
  logic           valid_d;
  logic           rd_en;
  logic [CW:0]    inflight;

  // cnt + pend never exceeds NIBBLES, so the extra bit only keeps the compare honest.
  assign inflight = {1'b0, cnt} + {{CW{1'b0}}, pend};

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state;
    cnt_d   = cnt;
    asm_d   = asm_word;
    word_d  = out_word;
    valid_d = out_valid & ~out_ready;
    rd_en   = 1'b0;

    case (state)
      FILL: begin
        rd_en = ~fifo_empty & (inflight < NIB_WIDE);
        if (pend) begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) asm_d[4*i +: 4] = fifo_data;
          end
          cnt_d = cnt + CW'(1);
          if (cnt_d == NIB_CNT) state_d = HOLD;
        end
      end
      HOLD: begin
        // The output register is free (empty, or emptying on this edge): hand the word over.
        if (!out_valid || out_ready) begin
          word_d  = asm_word;
          valid_d = 1'b1;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: the read strobe goes straight to the FIFO, so it is forced low while reset is held
  // rather than trusting the reset values of the registers it is decoded from.
  assign fifo_rd_en = rd_en & rd_rst;
  assign pend_d     = fifo_rd_en & ~fifo_empty;

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) state <= FILL;
    else         state <= state_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      cnt       <= '0;
      pend      <= 1'b0;
      asm_word  <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      pend      <= pend_d;
      asm_word  <= asm_d;
      out_word  <= word_d;
      out_valid <= valid_d;
    end
  end

`ifdef PACKER_PARITY_EN
  // Parity travels with out_word: loaded on the same edge, held under the same rules.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst)                                   out_parity <= 1'b0;
    else if (state == HOLD && (!out_valid || out_ready)) out_parity <= ^asm_word;
  end
`endif

  assign busy = (cnt != '0) | pend | (state == HOLD);

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Self-checking bench: two packers (NIBBLES=2 and 4) fed by a behavioural FIFO model,
// directed scenarios followed by random empty/ready toggling against a nibble scoreboard.
module tb_fifo_nibble_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rd_rst;
  logic        rd_en [2];
  logic        empty [2];
  logic [3:0]  data  [2];
  logic        valid [2];
  logic        ready [2];
  logic        busy  [2];
  logic        gate  [2];
  logic [7:0]  word2;
  logic [15:0] word4;
  logic [31:0] word  [2];
`ifdef PACKER_PARITY_EN
  logic        par   [2];
`endif

  always_comb begin
    word[0] = {24'b0, word2};
    word[1] = {16'b0, word4};
  end

  fifo_nibble_packer #(.NIBBLES(2)) u2 (
    .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(empty[0]), .fifo_data(data[0]),
    .fifo_rd_en(rd_en[0]), .out_word(word2), .out_valid(valid[0]), .out_ready(ready[0]),
    .busy(busy[0])
`ifdef PACKER_PARITY_EN
    , .out_parity(par[0])
`endif
  );

  fifo_nibble_packer #(.NIBBLES(4)) u4 (
    .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(empty[1]), .fifo_data(data[1]),
    .fifo_rd_en(rd_en[1]), .out_word(word4), .out_valid(valid[1]), .out_ready(ready[1]),
    .busy(busy[1])
`ifdef PACKER_PARITY_EN
    , .out_parity(par[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nib(input int l);
    return (l == 0) ? 2 : 4;
  endfunction

  // FIFO contents written by the stimulus; the model only advances a read index.
  logic [3:0]  stim  [2][$];
  int          rd_idx[2];
  logic        acc   [2];
  logic [3:0]  sb    [2][$];
  logic [31:0] got   [2][$];
  logic        gotp  [2][$];
  int          rdlog [2][$];
  int          vlog  [2][$];
  int          vcnt  [2];
  logic        prev_stall[2];
  logic        prev_valid[2];
  logic [31:0] prev_word [2];
  int          cyc = 0;

  // FIFO model + monitor: pop at negedge for reads accepted at the previous posedge, then
  // observe settled values that the next posedge will sample.
  initial begin
    for (int l = 0; l < 2; l++) begin
      empty[l] = 1'b1; data[l] = 4'h0; acc[l] = 1'b0; rd_idx[l] = 0; vcnt[l] = 0;
      prev_stall[l] = 1'b0; prev_valid[l] = 1'b0; prev_word[l] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int l = 0; l < 2; l++) begin
        if (acc[l]) begin
          data[l] = stim[l][rd_idx[l]];
          rd_idx[l]++;
          sb[l].push_back(data[l]);
        end
        empty[l] = (rd_idx[l] >= stim[l].size()) || gate[l];
      end
      #2;
      for (int l = 0; l < 2; l++) begin
        if (!rd_rst) begin
          sb[l].delete();
          prev_stall[l] = 1'b0;
          prev_valid[l] = 1'b0;
          acc[l] = 1'b0;
        end else begin
          check("rd_en_while_empty", 32'(rd_en[l] & empty[l]), 32'd0);
          if (prev_stall[l]) begin
            check("stall_valid", 32'(valid[l]), 32'd1);
            check("stall_word", word[l], prev_word[l]);
          end
          if (valid[l]) vcnt[l]++;
          if (valid[l] && !prev_valid[l]) vlog[l].push_back(cyc);
          if (rd_en[l] && !empty[l]) rdlog[l].push_back(cyc);
          if (valid[l] && ready[l]) begin
            if (sb[l].size() < nib(l)) begin
              check("scoreboard_underflow", 32'(sb[l].size()), 32'(nib(l)));
            end else begin
              logic [31:0] exp_w;
              exp_w = '0;
              for (int k = 0; k < nib(l); k++) exp_w |= 32'(sb[l].pop_front()) << (4 * k);
              check("word_order", word[l], exp_w);
`ifdef PACKER_PARITY_EN
              check("word_parity", 32'(par[l]), 32'(^exp_w));
              gotp[l].push_back(par[l]);
`endif
              got[l].push_back(word[l]);
            end
          end
          prev_stall[l] = valid[l] & ~ready[l];
          prev_valid[l] = valid[l];
          prev_word[l]  = word[l];
          acc[l]        = rd_en[l] & ~empty[l];
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int l, input logic [3:0] v);
    stim[l].push_back(v);
  endtask

  task automatic wait_got(input int l, input int n, input int budget);
    int k = 0;
    while (got[l].size() < n && k < budget) begin
      step(1);
      k++;
    end
    check("wait_words", 32'(got[l].size() >= n), 32'd1);
  endtask

  int bg, bg1, br, bv, bvc;
  int pushed[2];

  initial begin
    rd_rst = 1'b0;
    for (int l = 0; l < 2; l++) begin ready[l] = 1'b0; gate[l] = 1'b0; end
    step(3);
    check("rst_valid", 32'(valid[0]), 32'd0);
    check("rst_word", word[0], 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_rd_en", 32'(rd_en[0]), 32'd0);
    check("rst_word4", word[1], 32'd0);
    rd_rst = 1'b1;
    step(2);

    // Two nibbles, ready high: 0xA3, out_valid one cycle, NIBBLES+2 after first read.
    ready[0] = 1'b1;
    br = rdlog[0].size(); bv = vlog[0].size(); bvc = vcnt[0]; bg = got[0].size();
    push(0, 4'h3); push(0, 4'hA);
    wait_got(0, bg + 1, 50);
    step(3);
    if (got[0].size() > bg) check("t1_word", got[0][bg], 32'hA3);
    check("t1_reads", 32'(rdlog[0].size() - br), 32'd2);
    check("t1_vrise_seen", 32'(vlog[0].size() > bv), 32'd1);
    if (vlog[0].size() > bv && rdlog[0].size() > br)
      check("t1_latency", 32'(vlog[0][bv] - rdlog[0][br]), 32'd4);
    check("t1_valid_cycles", 32'(vcnt[0] - bvc), 32'd1);
    check("t1_busy_idle", 32'(busy[0]), 32'd0);

    // Backpressure: 0x21 held, 0x43 parked in HOLD, FIFO left with two nibbles.
    ready[0] = 1'b0;
    bg = got[0].size();
    for (int i = 1; i <= 6; i++) push(0, 4'(i));
    step(20);
    check("t2_valid", 32'(valid[0]), 32'd1);
    check("t2_word", word[0], 32'h21);
    check("t2_asm", 32'(u2.asm_word), 32'h43);
    check("t2_rd_en_hold", 32'(rd_en[0]), 32'd0);
    check("t2_busy", 32'(busy[0]), 32'd1);
    check("t2_fifo_left", 32'(stim[0].size() - rd_idx[0]), 32'd2);
    ready[0] = 1'b1;
    wait_got(0, bg + 3, 60);
    if (got[0].size() >= bg + 3) begin
      check("t2_w0", got[0][bg], 32'h21);
      check("t2_w1", got[0][bg+1], 32'h43);
      check("t2_w2", got[0][bg+2], 32'h65);
    end

    // NIBBLES=4 with an empty gap mid-word: cnt parks at 2.
    ready[1] = 1'b1;
    bg = got[1].size();
    push(1, 4'hF); push(1, 4'h0);
    step(5);
    check("t3_cnt_gap_a", 32'(u4.cnt), 32'd2);
    check("t3_busy_gap", 32'(busy[1]), 32'd1);
    step(5);
    check("t3_cnt_gap_b", 32'(u4.cnt), 32'd2);
    check("t3_no_word", 32'(valid[1]), 32'd0);
    push(1, 4'h5); push(1, 4'hC);
    wait_got(1, bg + 1, 40);
    if (got[1].size() > bg) check("t3_word", got[1][bg], 32'hC50F);

    // Asynchronous reset with a held word and one captured nibble.
    ready[0] = 1'b0;
    push(0, 4'h1); push(0, 4'h2); push(0, 4'h9);
    step(10);
    check("t4_pre_valid", 32'(valid[0]), 32'd1);
    check("t4_pre_cnt", 32'(u2.cnt), 32'd1);
    rd_rst = 1'b0;
    #1;
    check("t4_rst_valid", 32'(valid[0]), 32'd0);
    check("t4_rst_cnt", 32'(u2.cnt), 32'd0);
    check("t4_rst_busy", 32'(busy[0]), 32'd0);
    check("t4_rst_rd_en", 32'(rd_en[0]), 32'd0);
    step(2);
    rd_rst = 1'b1;
    ready[0] = 1'b1;
    bg = got[0].size();
    push(0, 4'h7); push(0, 4'h8);
    wait_got(0, bg + 1, 40);
    if (got[0].size() > bg) check("t4_word", got[0][bg], 32'h87);

`ifdef PACKER_PARITY_EN
    bg = got[0].size();
    push(0, 4'h3); push(0, 4'h1); push(0, 4'h3); push(0, 4'h3);
    wait_got(0, bg + 2, 40);
    if (got[0].size() >= bg + 2) begin
      check("t5_word_a", got[0][bg], 32'h13);
      check("t5_par_a", 32'(gotp[0][bg]), 32'd1);
      check("t5_word_b", got[0][bg+1], 32'h33);
      check("t5_par_b", 32'(gotp[0][bg+1]), 32'd0);
    end
`endif

    // Random empty/ready toggling, 10k nibbles across both packers.
    bg = got[0].size(); bg1 = got[1].size();
    pushed[0] = 0; pushed[1] = 0;
    for (int c = 0; c < 60000; c++) begin
      for (int l = 0; l < 2; l++) begin
        gate[l]  = ($urandom_range(0, 3) == 0);
        ready[l] = ($urandom_range(0, 9) < 7);
        if (pushed[l] < 5000 && (stim[l].size() - rd_idx[l]) < 16 && $urandom_range(0, 1) == 1) begin
          push(l, 4'($urandom_range(0, 15)));
          pushed[l]++;
        end
      end
      if (got[0].size() >= bg + 2500 && got[1].size() >= bg1 + 1250) break;
      step(1);
    end
    for (int l = 0; l < 2; l++) begin gate[l] = 1'b0; ready[l] = 1'b1; end
    step(10);
    check("rand_words_n2", 32'(got[0].size() - bg), 32'd2500);
    check("rand_words_n4", 32'(got[1].size() - bg1), 32'd1250);
    check("rand_sb_n2", 32'(sb[0].size()), 32'd0);
    check("rand_sb_n4", 32'(sb[1].size()), 32'd0);
    check("rand_idle_n2", 32'(busy[0] | valid[0]), 32'd0);
    check("rand_idle_n4", 32'(busy[1] | valid[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
